// File: rtl/seq_pkg.sv
// seq_pkg: shared widths, sequencer state encoding and opcode constants.
// STEP_WAIT exists only when STEP_MODE_EN is defined.
package seq_pkg;
    localparam int INSTR_W    = 9;
    localparam int FIFO_DEPTH = 4;
    localparam int LEVEL_W    = $clog2(FIFO_DEPTH + 1);
`ifdef STEP_MODE_EN
    typedef enum logic [1:0] {IDLE, EXEC, STEP_WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC} state_t;
`endif
    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] NAN = 3'b010;
    localparam logic [2:0] OUT = 3'b100;
    localparam logic [2:0] LDI = 3'b101;
    localparam logic [2:0] REP = 3'b111;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO with registered occupancy, full/empty flags and
// show-ahead read data; writes when full and reads when empty are ignored.
module instr_fifo #(
    parameter int W = 9,
    parameter int D = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(D+1)-1:0]     level
);
    localparam int AW = (D > 1) ? $clog2(D) : 1;
    localparam int LW = $clog2(D + 1);
    localparam logic [AW-1:0] LAST = AW'(D - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(D);
    logic [W-1:0] mem [D];
    logic [AW-1:0] wp, rp;
    logic wr, rd;
    assign full  = level == FULL_LEVEL;
    assign empty = level == '0;
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign rdata = mem[rp];
    always_ff @(posedge clock) begin
        if (wr) mem[wp] <= wdata;
    end
    always_ff @(posedge clock) begin
        if (resetn) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (wr) wp <= (wp == LAST) ? '0 : wp + 1'b1;
            if (rd) rp <= (rp == LAST) ? '0 : rp + 1'b1;
            level <= level + LW'(wr) - LW'(rd);
        end
    end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: queues instruction words and presents each to the control unit
// for four phases. Define STEP_MODE_EN to add the step port and STEP_WAIT state.
module instr_sequencer
    import seq_pkg::*;
(
    input  logic               clock,
    input  logic               resetn,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               halt,
`ifdef STEP_MODE_EN
    input  logic               step,
`endif
    output logic [INSTR_W-1:0] instr,
    output logic [1:0]         count,
    output logic               busy,
    output logic               done,
    output logic [LEVEL_W-1:0] fifo_level
);
    state_t state, state_n;
    logic [INSTR_W-1:0] head;
    logic full, empty, issue, last;
`ifdef STEP_MODE_EN
    localparam state_t AFTER = STEP_WAIT;
    assign issue = !empty && !halt && (state == IDLE || (state == STEP_WAIT && step));
`else
    localparam state_t AFTER = IDLE;
    assign issue = !empty && !halt && (state == IDLE || last);
`endif
    assign last     = state == EXEC && count == 2'b11;
    assign in_ready = !full;

    instr_fifo #(.W(INSTR_W), .D(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .resetn(resetn),
        .push  (in_valid && in_ready),
        .wdata (in_instr),
        .pop   (issue),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // count wraps 11->00 naturally, which is also its idle value
    always_ff @(posedge clock) begin
        if (resetn) begin
            state <= IDLE;
            count <= 2'b00;
            instr <= '0;
        end else begin
            state <= state_n;
            count <= (issue || state != EXEC) ? 2'b00 : count + 2'b01;
            instr <= issue ? head : instr;
        end
    end

    always_comb begin
        state_n = issue ? EXEC : last ? AFTER : state;
    end

    always_comb begin
        busy = state == EXEC;
        done = last;
    end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset: port "clock" clocks all state, and port "resetn" is synchronous and active-high despite its name.
REQ-002 Port: clock  input  1  rising-edge clock.
REQ-003 Port: resetn  input  1  synchronous active-high reset.
REQ-004 Port: in_instr  input  9  instruction word: op[8:6], ra[5:3], rb[2:0].
REQ-005 Port: in_valid  input  1  in_instr valid.
REQ-006 Port: in_ready  output  1  queue can accept; equals "queue not full".
REQ-007 Port: halt  input  1  inhibit issue of next instruction.
REQ-008 Port: instr  output  9  instruction presented to control unit "in".
REQ-009 Port: count  output  2  phase presented to control unit "count".
REQ-010 Port: busy  output  1  high while an instruction is executing.
REQ-011 Port: done  output  1  high during phase 11 of each instruction.
REQ-012 Port: fifo_level  output  3  queued entries, range 0..4.
REQ-013 Port (only with STEP_MODE_EN): step  input  1  single-step release.

Function
REQ-014 Queue SHALL be a 4-entry FIFO; push on a clock edge where in_valid && in_ready; no write when full; no bypass.
REQ-015 States SHALL be IDLE, EXEC and, with STEP_MODE_EN, STEP_WAIT.
REQ-016 IDLE -> EXEC on an edge where the FIFO is non-empty and halt=0: pop head into instr, count=00, busy=1.
REQ-017 In EXEC, count SHALL advance 00->01->10->11 one step per clock; instr SHALL be held stable for all four phases.
REQ-018 At the edge ending phase 11, if FIFO non-empty and halt=0, the next instruction SHALL load with count=00 (back-to-back, 4 clocks per instruction, no bubble); otherwise go to IDLE.
REQ-019 In IDLE: count=00, busy=0, done=0; instr holds its last value.
REQ-020 halt SHALL be sampled only at issue points (IDLE or end of phase 11); an instruction in progress always completes all four phases.
REQ-021 Latency: a word accepted on edge E into an empty FIFO while IDLE SHALL appear on instr with count=00 from edge E+1.
REQ-022 A simultaneous push and pop SHALL leave fifo_level unchanged and preserve FIFO order.
REQ-023 The sequencer SHALL be opcode-agnostic: every opcode, including unused 011 and 110, executes for exactly four phases unmodified.
REQ-024 fifo_level SHALL be registered and reflect pushes and pops of the same edge.

Reset
REQ-025 When resetn=1 at a clock edge: state=IDLE, FIFO flushed, fifo_level=0, instr=9'b0, count=00, busy=0, done=0, in_ready=1.
REQ-026 Reset asserted mid-instruction SHALL abort immediately; no further phases are issued and pushes in that cycle are discarded.

Configuration
REQ-027 With macro STEP_MODE_EN defined: port step exists; after phase 11 the FSM SHALL enter STEP_WAIT (count=00, busy=0) and issue the next instruction only on an edge with step=1, FIFO non-empty and halt=0.
REQ-028 Without STEP_MODE_EN: no step port, no STEP_WAIT state; behaviour per REQ-016..REQ-018.

Structure
REQ-029 Shared package seq_pkg SHALL hold: INSTR_W=9, FIFO_DEPTH=4, state enum, opcode constants ADD=000, SUB=001, NAN=010, OUT=100, LDI=101, REP=111.
REQ-030 The FIFO SHALL be a separate sub-module, instr_fifo (parameterised width/depth, full/empty/level).

Verification
REQ-031 Single issue: push 9'b000_001_010 (ADD r1,r2) while IDLE -> count 00,01,10,11 over next 4 cycles, done high only in the 4th, then IDLE.
REQ-032 Back-to-back: push 4 words (ADD, SUB, NAN, LDI) -> 16 consecutive busy cycles, count wrapping 11->00 with no gap, FIFO order preserved.
REQ-033 Full: push 5 words with no issue (halt=1) -> in_ready=0 after the 4th, fifo_level=4, 5th word not stored.
REQ-034 Halt: assert halt during phase 01 of instruction 1 with 2 queued -> instruction 1 completes, then IDLE with fifo_level=2; deassert -> issue on next edge.
REQ-035 Reset mid-op: resetn=1 during phase 10 with 3 queued -> next cycle count=00, busy=0, fifo_level=0, instr=0.
REQ-036 STEP_MODE_EN: 2 queued -> first executes, then STEP_WAIT until a 1-cycle step pulse; second begins count=00 on the following edge.
